// File: rtl/syncro_pkg.sv
// ============================================================================
// Module   : syncro_pkg
// Purpose  : Shared limits and counter-width helper for the syncro_n family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package syncro_pkg;

  localparam int SYNCRO_MIN_STAGES   = 2;
  localparam int SYNCRO_MAX_STAGES   = 4;
  localparam int SYNCRO_MAX_FILT     = 255;
  localparam int SYNCRO_MIN_FILT     = 2;
  localparam int SYNCRO_MAX_CHANNELS = 32;

  // Counter must hold FILT_LEN-1; never narrower than one bit.
  function automatic int syncro_cnt_width(input int filt_len);
    return (filt_len <= 2) ? 1 : $clog2(filt_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/syncro_n_filt.sv
// ============================================================================
// Module   : syncro_n_filt
// Purpose  : Per-channel glitch filter; a new level is accepted only after it
//            has persisted FILT_LEN consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syncro_n_filt
  import syncro_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int                 c_cnt_w = syncro_cnt_width(FILT_LEN);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(FILT_LEN - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic               w_diff;

  assign w_diff = din ^ r_level;

  // Any return to the accepted level restarts the count from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_diff) begin
      r_cnt   <= '0;
    end else if (r_cnt == c_last) begin
      r_level <= din;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  assign dout = r_level;

endmodule

`default_nettype wire

// File: rtl/syncro_n.sv
// ============================================================================
// Module   : syncro_n
// Purpose  : Multi-channel asynchronous-level synchroniser with edge pulses.
//            Optional glitch filter selected by macro SYNCRO_N_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syncro_n
  import syncro_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int STAGES   = 2,
  parameter int FILT_LEN = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise_out,
  output logic [CHANNELS-1:0] fall_out
);

  if (CHANNELS < 1 || CHANNELS > SYNCRO_MAX_CHANNELS) begin : g_bad_channels
    $fatal(1, "syncro_n: CHANNELS=%0d out of range 1..%0d", CHANNELS, SYNCRO_MAX_CHANNELS);
  end
  if (STAGES < SYNCRO_MIN_STAGES || STAGES > SYNCRO_MAX_STAGES) begin : g_bad_stages
    $fatal(1, "syncro_n: STAGES=%0d out of range %0d..%0d", STAGES, SYNCRO_MIN_STAGES, SYNCRO_MAX_STAGES);
  end

  logic [CHANNELS-1:0] w_chain;
  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] r_prev;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_sync <= '0;
      else          r_sync <= {r_sync[STAGES-2:0], sig_in[g]};
    end

    assign w_chain[g] = r_sync[STAGES-1];

`ifdef SYNCRO_N_FILTER_EN
    syncro_n_filt #(
      .FILT_LEN (FILT_LEN)
    ) u_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (w_chain[g]),
      .dout    (w_level[g])
    );
`else
    assign w_level[g] = w_chain[g];
`endif
  end

`ifdef SYNCRO_N_FILTER_EN
  if (FILT_LEN < SYNCRO_MIN_FILT || FILT_LEN > SYNCRO_MAX_FILT) begin : g_bad_filt
    $fatal(1, "syncro_n: FILT_LEN=%0d out of range %0d..%0d", FILT_LEN, SYNCRO_MIN_FILT, SYNCRO_MAX_FILT);
  end
`else
  // FILT_LEN has no effect without the filter.
  logic w_filt_len_unused;
  assign w_filt_len_unused = FILT_LEN[0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev <= '0;
    else          r_prev <= w_level;
  end

  assign sig_out  = w_level;
  assign rise_out = w_level & ~r_prev;
  assign fall_out = ~w_level & r_prev;

endmodule

`default_nettype wire

// File: tb/tb_syncro_n.sv
// ============================================================================
// Module   : tb_syncro_n
// Purpose  : Directed self-checking bench for syncro_n (both builds, selected
//            by SYNCRO_N_FILTER_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_syncro_n;

`ifdef SYNCRO_N_FILTER_EN
  localparam int F = 4;
`else
  localparam int F = 0;
`endif
  localparam int LAT_A = 2 + F;
  localparam int LAT_B = 3 + F;
  localparam int LAT_C = 2 + F;
  localparam int N_RND = 160;

  logic       clk;
  logic       reset_n;
  logic [1:0] sig_a, out_a, rise_a, fall_a;
  logic [1:0] sig_b, out_b, rise_b, fall_b;
  logic [7:0] sig_c, out_c, rise_c, fall_c;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] hist [0:N_RND+LAT_C];

  syncro_n #(.CHANNELS(2), .STAGES(2), .FILT_LEN(4)) u_a (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_a),
    .sig_out(out_a), .rise_out(rise_a), .fall_out(fall_a));

  syncro_n #(.CHANNELS(2), .STAGES(3), .FILT_LEN(4)) u_b (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_b),
    .sig_out(out_b), .rise_out(rise_b), .fall_out(fall_b));

  syncro_n #(.CHANNELS(8), .STAGES(2), .FILT_LEN(4)) u_c (
    .clk(clk), .reset_n(reset_n), .sig_in(sig_c),
    .sig_out(out_c), .rise_out(rise_c), .fall_out(fall_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_c(input int m);
    return (m - LAT_C >= 0) ? hist[m - LAT_C] : 8'h00;
  endfunction

  initial begin
    int rise_cnt0, rise_cnt1, fall_cnt;
    int hold;
    int n_trans, n_pulse;
    logic [7:0] cur, e_now, e_prev;

    reset_n = 1'b0;
    sig_a   = 2'b00;
    sig_b   = 2'b11;
    sig_c   = 8'h00;
    repeat (3) tick();
    chk("reset_out_a", 32'(out_a), 32'h0);
    chk("reset_out_b", 32'(out_b), 32'h0);
    chk("reset_pulse_b", 32'({rise_b, fall_b}), 32'h0);
    chk("reset_out_c", 32'({out_c, rise_c, fall_c}), 32'h0);

    // Input held high through reset release: one rise per channel.
    reset_n   = 1'b1;
    rise_cnt0 = 0;
    rise_cnt1 = 0;
    fall_cnt  = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      rise_cnt0 += int'(rise_b[0]);
      rise_cnt1 += int'(rise_b[1]);
      fall_cnt  += int'(fall_b[0]) + int'(fall_b[1]);
    end
    chk("release_rise_ch0", 32'(rise_cnt0), 32'd1);
    chk("release_rise_ch1", 32'(rise_cnt1), 32'd1);
    chk("release_fall", 32'(fall_cnt), 32'd0);
    chk("release_out_b", 32'(out_b), 32'h3);
    chk("release_out_a", 32'(out_a), 32'h0);

    // Single-channel rise on A.
    sig_a = 2'b01;
    for (int i = 1; i <= LAT_A + 2; i++) begin
      tick();
      chk("a_rise_out",   32'(out_a),  32'((i >= LAT_A) ? 2'b01 : 2'b00));
      chk("a_rise_pulse", 32'(rise_a), 32'((i == LAT_A) ? 2'b01 : 2'b00));
      chk("a_rise_fall",  32'(fall_a), 32'h0);
    end

    // Simultaneous fall on both channels of B.
    sig_b = 2'b00;
    for (int i = 1; i <= LAT_B + 2; i++) begin
      tick();
      chk("b_fall_out",   32'(out_b),  32'((i >= LAT_B) ? 2'b00 : 2'b11));
      chk("b_fall_pulse", 32'(fall_b), 32'((i == LAT_B) ? 2'b11 : 2'b00));
      chk("b_fall_rise",  32'(rise_b), 32'h0);
    end

`ifdef SYNCRO_N_FILTER_EN
    sig_a = 2'b00;
    repeat (12) tick();
    chk("f_pre_glitch", 32'(out_a), 32'h0);

    // Three-cycle glitch is swallowed.
    sig_a = 2'b01;
    repeat (3) tick();
    sig_a = 2'b00;
    for (int i = 0; i < 12; i++) begin
      chk("f_glitch_out",   32'(out_a), 32'h0);
      chk("f_glitch_pulse", 32'({rise_a, fall_a}), 32'h0);
      tick();
    end

    // Four-cycle-stable level is accepted at STAGES+FILT_LEN.
    sig_a = 2'b01;
    for (int i = 1; i <= LAT_A + 2; i++) begin
      tick();
      chk("f_accept_out",  32'(out_a),  32'((i >= LAT_A) ? 2'b01 : 2'b00));
      chk("f_accept_rise", 32'(rise_a), 32'((i == LAT_A) ? 2'b01 : 2'b00));
    end

    // Reset in the middle of a pending count discards it.
    sig_a = 2'b00;
    repeat (12) tick();
    sig_a = 2'b01;
    repeat (4) tick();
    reset_n = 1'b0;
    sig_a   = 2'b00;
    #1;
    chk("f_midreset_out", 32'({out_a, rise_a, fall_a}), 32'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("f_after_reset_out", 32'({out_a, rise_a, fall_a}), 32'h0);
    end
`endif

    // Random toggles on C against a pure delay reference.
    hold = 0;
    cur  = 8'h00;
    for (int j = 0; j <= N_RND + LAT_C; j++) begin
      if (hold == 0) begin
        cur  = 8'($urandom);
        hold = (F > 0) ? int'($urandom_range(F + 2, F)) : int'($urandom_range(3, 1));
      end
      hist[j] = cur;
      hold--;
    end
    n_trans = 0;
    n_pulse = 0;
    for (int m = 1; m <= N_RND; m++) begin
      sig_c = hist[m-1];
      tick();
      e_now  = ref_c(m);
      e_prev = ref_c(m - 1);
      chk("c_out",  32'(out_c),  32'(e_now));
      chk("c_rise", 32'(rise_c), 32'(e_now & ~e_prev));
      chk("c_fall", 32'(fall_c), 32'(~e_now & e_prev));
      chk("c_both", 32'(rise_c & fall_c), 32'h0);
      n_trans += $countones(e_now ^ e_prev);
      n_pulse += $countones(rise_c) + $countones(fall_c);
    end
    chk("c_pulse_total", 32'(n_pulse), 32'(n_trans));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/syncro_n.md
SYNCRO_N -- requirements
Module: syncro_n

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent asynchronous inputs, range 1..32.
REQ-002 SHALL have parameter STAGES, default 2: synchroniser flop depth per channel, range 2..4.
REQ-003 SHALL have parameter FILT_LEN, default 4: cycles a new level must persist before acceptance (filter build only), range 2..255.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all flops are on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port sig_in, input, CHANNELS bits: asynchronous levels, one per channel.
REQ-007 SHALL have port sig_out, output, CHANNELS bits: synchronised (and filtered, if built) levels.
REQ-008 SHALL have port rise_out, output, CHANNELS bits: one-cycle pulse on each sig_out 0->1 transition.
REQ-009 SHALL have port fall_out, output, CHANNELS bits: one-cycle pulse on each sig_out 1->0 transition.

Function
REQ-010 SHALL pass each sig_in bit through a chain of STAGES flops tagged ASYNC_REG="TRUE", with no logic between chain flops.
REQ-011 SHALL, without filter, drive sig_out from the last chain flop: a stable input change appears on sig_out STAGES cycles later.
REQ-012 SHALL keep a registered previous copy of sig_out per channel: rise_out = sig_out & ~prev and fall_out = ~sig_out & prev, so a pulse coincides with the first cycle of the new sig_out level.
REQ-013 SHALL never assert rise_out and fall_out for the same channel in the same cycle.
REQ-014 SHALL treat channels fully independently; simultaneous changes on several channels produce simultaneous pulses.
REQ-015 SHALL, with filter, give each channel a counter of width clog2(FILT_LEN) and a filtered-level flop that drives sig_out.
REQ-016 SHALL clear a channel's counter in any cycle where its chain output equals its filtered level.
REQ-017 SHALL increment the counter in any cycle where the chain output differs and the count is below FILT_LEN-1.
REQ-018 SHALL, when the count is FILT_LEN-1 and the chain output still differs, load the filtered level from the chain output and clear the counter.
REQ-019 SHALL result, with filter, in a latency of STAGES+FILT_LEN cycles from a stable input change to sig_out.
REQ-020 SHALL, with filter, suppress any chain-output excursion shorter than FILT_LEN cycles, producing no sig_out change and no pulse.
REQ-021 SHALL restart the count from zero when an excursion ends before acceptance; counts never carry over between excursions.

Reset
REQ-022 SHALL, on reset_n low, asynchronously clear all chain flops, prev flops, filtered levels and counters.
REQ-023 SHALL hold sig_out, rise_out and fall_out at 0 during reset.
REQ-024 SHALL release reset synchronously to clk; reset_n is already synchronised externally.
REQ-025 SHALL, when sig_in is 1 at reset release, raise sig_out after the normal latency and emit exactly one rise_out pulse.
REQ-026 SHALL, when reset is asserted mid-count, discard the pending change entirely.

Configuration
REQ-027 SHALL use macro SYNCRO_N_FILTER_EN to select the build.
REQ-028 SHALL, when SYNCRO_N_FILTER_EN is defined, instantiate the glitch filter (REQ-015..REQ-021).
REQ-029 SHALL, when SYNCRO_N_FILTER_EN is undefined, contain no counters or filter flops, and FILT_LEN SHALL be ignored.

Structure
REQ-030 SHALL take the constants SYNCRO_MIN_STAGES=2, SYNCRO_MAX_STAGES=4 and SYNCRO_MAX_FILT=255, and the counter-width function, from shared package syncro_pkg.
REQ-031 SHALL implement the per-channel filter (counter plus filtered-level flop) as sub-module syncro_n_filt, generated CHANNELS times.
REQ-032 SHALL reject out-of-range parameters at elaboration with a fatal error.

Verification
REQ-033 SHALL verify: no filter, CHANNELS=2, STAGES=2; sig_in[0] 0->1 at cycle 10 -> sig_out[0]=1 from cycle 12, rise_out[0]=1 only at cycle 12, channel 1 quiet.
REQ-034 SHALL verify: STAGES=3, sig_in=2'b11 -> 2'b00 -> fall_out=2'b11 for exactly one cycle, 3 cycles after the input change.
REQ-035 SHALL verify: filter, FILT_LEN=4; a 3-cycle high glitch -> no sig_out change and no pulses; a 4-cycle-stable high -> sig_out=1 at latency 6 with one rise_out.
REQ-036 SHALL verify: filter; reset_n pulsed low at count 2 of a pending change -> all outputs 0 and the change is never accepted unless re-presented for 4 cycles.
REQ-037 SHALL verify: sig_in held 1 through reset release -> exactly one rise_out per channel, no fall_out.
REQ-038 SHALL verify: CHANNELS=8 with random asynchronous toggles -> every sig_out transition has exactly one matching pulse, checked by a scoreboard against a reference delay model.
